// File: rtl/ot_score_encoder.sv
// Game-status encoder: keeps both scores and emits one-cycle 3-bit event
// codes (regulation win, overtime tie/advantage/win) for the overtime FSM.
module ot_score_encoder #(
    parameter int WIN_SCORE = 13,
    parameter int SCORE_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic               p1_point,
    input  logic               p2_point,
    output logic [2:0]         intake,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               protocol_err
);

    typedef enum logic [2:0] {
        S_REG    = 3'd0,
        S_OT_NEU = 3'd1,
        S_OT_P1  = 3'd2,
        S_OT_P2  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [2:0] C_IDLE    = 3'b000;
    localparam logic [2:0] C_NEUTRAL = 3'b001;
    localparam logic [2:0] C_OT_P1   = 3'b010;
    localparam logic [2:0] C_OT_P2   = 3'b011;
    localparam logic [2:0] C_WIN_P1  = 3'b100;
    localparam logic [2:0] C_WIN_P2  = 3'b101;

    localparam logic [SCORE_W-1:0] SMAX   = '1;
    localparam logic [SCORE_W-1:0] TIE_SC = SCORE_W'(WIN_SCORE - 1);
    localparam logic [SCORE_W-1:0] WIN_SC = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [SCORE_W-1:0] p1_inc, p2_inc;
    logic [2:0]         intake_q, intake_d;
    logic               go_q, go_d;
    logic [1:0]         winner_q, winner_d;
    logic               perr_q, perr_d;

    // Saturating increments: a score parks at all-ones instead of wrapping.
    assign p1_inc = (p1_q == SMAX) ? p1_q : p1_q + SCORE_W'(1);
    assign p2_inc = (p2_q == SMAX) ? p2_q : p2_q + SCORE_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_REG;
            p1_q     <= '0;
            p2_q     <= '0;
            intake_q <= C_IDLE;
            go_q     <= 1'b0;
            winner_q <= 2'b00;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            intake_q <= intake_d;
            go_q     <= go_d;
            winner_q <= winner_d;
            perr_q   <= perr_d;
        end
    end

    // intake_d defaults to idle every cycle so no code is ever held.
    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        intake_d = C_IDLE;
        go_d     = go_q;
        winner_d = winner_q;
        perr_d   = 1'b0;
        if (new_game) begin
            state_d  = S_REG;
            p1_d     = '0;
            p2_d     = '0;
            go_d     = 1'b0;
            winner_d = 2'b00;
        end else if (p1_point && p2_point) begin
            perr_d = 1'b1;
        end else if ((p1_point || p2_point) && state_q != S_DONE) begin
            p1_d = p1_point ? p1_inc : p1_q;
            p2_d = p2_point ? p2_inc : p2_q;
            case (state_q)
                S_REG: begin
                    if (p1_d == TIE_SC && p2_d == TIE_SC) begin
                        intake_d = C_NEUTRAL;
                        state_d  = S_OT_NEU;
                    end else if (p1_point && p1_d == WIN_SC) begin
                        intake_d = C_WIN_P1;
                        state_d  = S_DONE;
                        go_d     = 1'b1;
                        winner_d = 2'b01;
                    end else if (p2_point && p2_d == WIN_SC) begin
                        intake_d = C_WIN_P2;
                        state_d  = S_DONE;
                        go_d     = 1'b1;
                        winner_d = 2'b10;
                    end
                end
                S_OT_NEU: begin
                    intake_d = p1_point ? C_OT_P1 : C_OT_P2;
                    state_d  = p1_point ? S_OT_P1 : S_OT_P2;
                end
                S_OT_P1: begin
                    if (p1_point) begin
                        intake_d = C_OT_P1;
                        state_d  = S_DONE;
                        go_d     = 1'b1;
                        winner_d = 2'b01;
                    end else begin
                        intake_d = C_NEUTRAL;
                        state_d  = S_OT_NEU;
                    end
                end
                S_OT_P2: begin
                    if (p2_point) begin
                        intake_d = C_OT_P2;
                        state_d  = S_DONE;
                        go_d     = 1'b1;
                        winner_d = 2'b10;
                    end else begin
                        intake_d = C_NEUTRAL;
                        state_d  = S_OT_NEU;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        intake       = intake_q;
        p1_score     = p1_q;
        p2_score     = p2_q;
        game_over    = go_q;
        winner       = winner_q;
        protocol_err = perr_q;
    end

endmodule

// File: tb/tb_ot_score_encoder.sv
// Scoreboard bench for ot_score_encoder: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_ot_score_encoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       new_game = 1'b0;
    logic       p1_point = 1'b0;
    logic       p2_point = 1'b0;
    logic [2:0] intake;
    logic [4:0] p1_score, p2_score;
    logic       game_over;
    logic [1:0] winner;
    logic       protocol_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int    cyc;
        int    intake;
        int    p1;
        int    p2;
        int    go;
        int    win;
        int    perr;
        string name;
    } exp_t;

    exp_t sb[$];

    ot_score_encoder #(.WIN_SCORE(13), .SCORE_W(5)) dut (
        .clk(clk), .reset(reset), .new_game(new_game),
        .p1_point(p1_point), .p2_point(p2_point),
        .intake(intake), .p1_score(p1_score), .p2_score(p2_score),
        .game_over(game_over), .winner(winner), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    task automatic step(input logic a, input logic b, input logic ng,
                        input int ei, input int e1, input int e2,
                        input int ego, input int ew, input int ep, input string nm);
        exp_t e;
        @(negedge clk);
        p1_point = a;
        p2_point = b;
        new_game = ng;
        e.cyc = cyc + 1; e.intake = ei; e.p1 = e1; e.p2 = e2;
        e.go = ego; e.win = ew; e.perr = ep; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic idle(input int e1, input int e2, input int ego, input int ew, input string nm);
        step(1'b0, 1'b0, 1'b0, 0, e1, e2, ego, ew, 0, nm);
    endtask

    task automatic to_tie();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0, 0, i + 1, i, 0, 0, 0, "alt_p1");
            step(1'b0, 1'b1, 1'b0, (i == 11) ? 1 : 0, i + 1, i + 1, 0, 0, 0, "alt_p2");
        end
    endtask

    // Monitor: compare queued expectations on their cycle, otherwise the
    // event outputs must be idle.
    always @(negedge clk) begin
        if (reset) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                exp_t s;
                s = sb.pop_front();
                chk({s.name, "_stale"}, 1, 0);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_intake"}, int'(intake), e.intake);
                chk({e.name, "_p1"}, int'(p1_score), e.p1);
                chk({e.name, "_p2"}, int'(p2_score), e.p2);
                chk({e.name, "_game_over"}, int'(game_over), e.go);
                chk({e.name, "_winner"}, int'(winner), e.win);
                chk({e.name, "_perr"}, int'(protocol_err), e.perr);
            end else begin
                chk("unexpected_event", int'(intake != 3'b000 || protocol_err), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, prev;
        repeat (2) @(negedge clk);
        chk("rst_intake", int'(intake), 0);
        chk("rst_p1", int'(p1_score), 0);
        chk("rst_p2", int'(p2_score), 0);
        chk("rst_go", int'(game_over), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_perr", int'(protocol_err), 0);
        reset = 1'b1;

        // Regulation win for player 1, pulses spaced two cycles apart.
        for (int i = 1; i <= 13; i++) begin
            step(1'b1, 1'b0, 1'b0, (i == 13) ? 4 : 0, i, 0,
                 (i == 13) ? 1 : 0, (i == 13) ? 1 : 0, 0, "reg_p1");
            idle(i, 0, (i == 13) ? 1 : 0, (i == 13) ? 1 : 0, "reg_gap");
        end
        step(1'b1, 1'b0, 1'b0, 0, 13, 0, 1, 1, 0, "done_ignored");
        step(1'b1, 1'b1, 1'b0, 0, 13, 0, 1, 1, 1, "done_perr");
        step(1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, "newgame_prio");
        idle(0, 0, 0, 0, "newgame_idle");

        // Tie into overtime, then p1,p2,p2,p2 back to back.
        to_tie();
        idle(12, 12, 0, 0, "tie_idle");
        step(1'b1, 1'b0, 1'b0, 2, 13, 12, 0, 0, 0, "ot_p1_adv");
        step(1'b0, 1'b1, 1'b0, 1, 13, 13, 0, 0, 0, "ot_deuce");
        step(1'b0, 1'b1, 1'b0, 3, 13, 14, 0, 0, 0, "ot_p2_adv");
        step(1'b0, 1'b1, 1'b0, 3, 13, 15, 1, 2, 0, "ot_p2_win");
        idle(13, 15, 1, 2, "ot_after_win");

        // Overtime ping-pong up to and past score saturation.
        step(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, "ng2");
        to_tie();
        prev = 12;
        for (int k = 1; k <= 20; k++) begin
            s = (12 + k > 31) ? 31 : 12 + k;
            step(1'b1, 1'b0, 1'b0, 2, s, prev, 0, 0, 0, "sat_p1");
            step(1'b0, 1'b1, 1'b0, 1, s, s, 0, 0, 0, "sat_p2");
            prev = s;
        end
        idle(31, 31, 0, 0, "sat_idle");

        // Simultaneous pulses at 5-3.
        step(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, "ng3");
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, 0, i, 0, 0, 0, 0, "pe_p1");
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b0, 0, 5, i, 0, 0, 0, "pe_p2");
        step(1'b1, 1'b1, 1'b0, 0, 5, 3, 0, 0, 1, "perr");
        idle(5, 3, 0, 0, "perr_clear");
        step(1'b1, 1'b0, 1'b0, 0, 6, 3, 0, 0, 0, "after_perr");

        // Asynchronous reset mid-cycle at 7-9.
        step(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0, "ng4");
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b0, 1'b0, 0, i, i - 1, 0, 0, 0, "ar_p1");
            step(1'b0, 1'b1, 1'b0, 0, i, i, 0, 0, 0, "ar_p2");
        end
        step(1'b0, 1'b1, 1'b0, 0, 7, 8, 0, 0, 0, "ar_p2b");
        step(1'b0, 1'b1, 1'b0, 0, 7, 9, 0, 0, 0, "ar_p2c");
        idle(7, 9, 0, 0, "ar_idle");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_p1", int'(p1_score), 0);
        chk("async_p2", int'(p2_score), 0);
        chk("async_intake", int'(intake), 0);
        chk("async_go", int'(game_over), 0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b1, 1'b0, 0, 0, 1, 0, 0, 0, "post_reset_p2");
        idle(0, 1, 0, 0, "post_reset_idle");

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ot_score_encoder.md
Name: ot_score_encoder

Overview:
- Producer side of the 3-bit game-status code consumed by the overtime FSM.
- Takes one-cycle point pulses for each player and keeps both scores. Detects the regulation win, the tie that triggers overtime, and advantage/deuce/win events during overtime.
- Emits the matching 3-bit code as a registered one-cycle pulse. Idle code is 000.
- Sits between the debounced player-button logic and the overtime FSM. The scores also drive the display.

Parameters:
- WIN_SCORE, 13: points needed to win in regulation. Overtime triggers at WIN_SCORE-1 all. Legal range 2..(2^SCORE_W - 2).
- SCORE_W, 5: width of each score counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- new_game  input  1  synchronous clear to start of game. Has priority over point pulses.
- p1_point  input  1  one-cycle pulse: player 1 scored.
- p2_point  input  1  one-cycle pulse: player 2 scored.
- intake  output  3  status code to the overtime FSM. Registered; each event code lasts one cycle, otherwise 000.
- p1_score  output  SCORE_W  player 1 score.
- p2_score  output  SCORE_W  player 2 score.
- game_over  output  1  high from the win event until new_game or reset.
- winner  output  2  00 none, 01 player 1, 10 player 2. Valid while game_over.
- protocol_err  output  1  one-cycle pulse when p1_point and p2_point are high in the same cycle.

Behaviour:
- Reset (reset=0, async): state REG; intake=000; scores=0; game_over=0; winner=00; protocol_err=0.
- new_game=1 gives the same values as reset on the next edge, from any state.
- Codes: 000 idle/no event; 001 tie at WIN_SCORE-1 all, or back to neutral; 010 player 1 scores in overtime; 011 player 2 scores in overtime; 100 player 1 regulation win; 101 player 2 regulation win.
- Latency: a point pulse in cycle N gives the updated scores and code in cycle N+1. intake returns to 000 in cycle N+2 unless another point arrives in cycle N+1.
- Back-to-back pulses on consecutive cycles are each processed.
- A code is never held for more than one cycle. The downstream FSM samples every cycle, and a held 010/011 would double-advance it.
- Simultaneous p1_point and p2_point: both ignored; state and scores unchanged; intake=000; protocol_err=1 for one cycle.
- Only point pulses in REG, OT_NEU, OT_P1 and OT_P2 update the scores.
- Scores saturate at 2^SCORE_W - 1 and never wrap.
- States:
  - REG:
    - Scorer's score increments.
    - If the new scores are WIN_SCORE-1 all: intake=001, go to OT_NEU.
    - Else if the scorer reaches WIN_SCORE: intake=100 (p1) or 101 (p2); go to DONE; game_over=1; winner set.
    - Else intake=000.
  - OT_NEU:
    - p1 point: intake=010, go to OT_P1.
    - p2 point: intake=011, go to OT_P2.
  - OT_P1:
    - p1 point: intake=010, go to DONE, winner=01.
    - p2 point: intake=001, go to OT_NEU.
  - OT_P2:
    - p2 point: intake=011, go to DONE, winner=10.
    - p1 point: intake=001, go to OT_NEU.
  - DONE:
    - Point pulses ignored; no score change; intake=000. protocol_err still reported.
    - Exit only by new_game or reset.
- Reset mid-operation: outputs clear immediately (asynchronously), whatever the state. An in-flight code pulse is cut off.
- In regulation a player cannot reach WIN_SCORE while the other holds WIN_SCORE-1, because the tie forces overtime first.

Test Plan:
- Reset, then 13 p1_point pulses spaced 2 cycles apart -> p1_score=13, p2_score=0. intake=100 for exactly one cycle after the 13th pulse. game_over=1, winner=01. A further p1_point leaves score at 13 and intake at 000.
- Alternate p1/p2 pulses up to 12-12 -> intake=001 for one cycle after the 24th pulse; state OT_NEU; game_over=0.
- From 12-12, pulses p1,p2,p2,p2 on consecutive cycles -> intake sequence 010,001,011,011, then 000. winner=10; scores 13/15.
- p1_point and p2_point high in the same cycle at 5-3 -> protocol_err=1 for one cycle; scores stay 5-3; intake=000.
- Drop reset to 0 mid-cycle at 7-9 while intake=000 -> scores and outputs read 0 before the next clock edge. After release, the first p2_point gives p2_score=1.
- In DONE, assert new_game together with p1_point -> next cycle scores 0-0, game_over=0, winner=00, intake=000.
